// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and sequencer for the shared instruction/data memory port.
// Optional define ARB_CORE_PRIORITY_EN selects fixed core priority instead of round-robin.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned   CW       = 4;
  localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);
  localparam logic          REQ_CORE = 1'b0;
  localparam logic          REQ_EXT  = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          owner, owner_next;
  logic          winner;

`ifndef ARB_CORE_PRIORITY_EN
  logic rr_last, rr_next;

  // Round-robin history; reset to EXT so the core takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_last <= REQ_EXT;
    else       rr_last <= rr_next;
  end
`endif

  // Winner selection: sole requester, or tie-break.
  always_comb begin
    if (core_req && ext_req) begin
`ifdef ARB_CORE_PRIORITY_EN
      winner = REQ_CORE;
`else
      winner = ~rr_last;
`endif
    end else begin
      winner = ext_req ? REQ_EXT : REQ_CORE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= REQ_CORE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      owner <= owner_next;
    end
  end

  // Next state and command/response routing; everything held at 0 during reset.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    owner_next  = owner;
`ifndef ARB_CORE_PRIORITY_EN
    rr_next     = rr_last;
`endif
    core_gnt    = 1'b0;
    core_rvalid = 1'b0;
    core_rdata  = '0;
    ext_gnt     = 1'b0;
    ext_rvalid  = 1'b0;
    ext_rdata   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = 1'b0;

    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (core_req || ext_req) begin
            mem_en     = 1'b1;
            owner_next = winner;
`ifndef ARB_CORE_PRIORITY_EN
            rr_next    = winner;
`endif
            if (winner == REQ_EXT) begin
              ext_gnt   = 1'b1;
              mem_we    = ext_we;
              mem_addr  = ext_addr;
              mem_wdata = ext_wdata;
            end else begin
              core_gnt  = 1'b1;
              mem_we    = core_we;
              mem_addr  = core_addr;
              mem_wdata = core_wdata;
            end
            // Writes complete in the grant cycle; reads wait out the latency.
            if (!mem_we) begin
              state_next = RD_WAIT;
              cnt_next   = LAT_INIT;
            end
          end
        end
        RD_WAIT: begin
          busy = 1'b1;
          if (cnt == '0) begin
            state_next = IDLE;
            if (owner == REQ_EXT) begin
              ext_rvalid = 1'b1;
              ext_rdata  = mem_rdata;
            end else begin
              core_rvalid = 1'b1;
              core_rdata  = mem_rdata;
            end
          end else begin
            cnt_next = cnt - CW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single unified instruction/data memory port of the multicycle ARM core. Requester 0 is the core's memory interface (fetch, LDR, STR). Requester 1 is the external loader/debug port. The block grants one transaction at a time, drives the shared memory command, and counts fixed read latency before routing read data back to the owner.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, cycles from memory command to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
core_req  in  1  core requests an access; held with cmd fields stable until core_gnt
core_we  in  1  1 = write, 0 = read
core_addr  in  AW  core address
core_wdata  in  DW  core write data
core_gnt  out  1  one-cycle pulse; core command issued this cycle
core_rvalid  out  1  one-cycle pulse; core_rdata valid
core_rdata  out  DW  read data to core
ext_req  in  1  external requester request, same rules as core_req
ext_we  in  1  external write enable
ext_addr  in  AW  external address
ext_wdata  in  DW  external write data
ext_gnt  out  1  one-cycle grant pulse
ext_rvalid  out  1  one-cycle read-data-valid pulse
ext_rdata  out  DW  read data to external port
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  out  1  high while a read is outstanding (state RD_WAIT)

Behaviour:
- Reset (async): state IDLE, latency counter 0, owner 0, rr_last = EXT (so the core wins the first tie). All outputs are forced to 0 while reset is high, including combinational gnt/mem_en.
- FSM states: IDLE, RD_WAIT.
- IDLE, no req: all strobes 0; mem_addr/mem_wdata are don't-care but driven 0.
- IDLE with one or both req:
  - Pick winner: the sole requester, or on a tie the requester not equal to rr_last.
  - In the same cycle, combinationally: winner gnt = 1, mem_en = 1, mem_we/addr/wdata = winner fields.
  - On the clock edge: rr_last <= winner, owner <= winner.
- Write grant: stay IDLE. A new grant is possible the next cycle (1 write per cycle max).
- Read grant: go to RD_WAIT with counter <= MEM_LAT-1.
- RD_WAIT:
  - No grants; mem_en = 0; busy = 1.
  - Counter decrements each cycle.
  - When counter == 0, the owner's rvalid = 1 and its rdata = mem_rdata (combinational route) for exactly that cycle; next state IDLE.
  - Read latency seen by the requester: gnt at cycle T, rvalid at cycle T+MEM_LAT. Back-to-back read grants are MEM_LAT+1 cycles apart.
- rdata of the non-owner, or when rvalid = 0: 0.
- Requests arriving during RD_WAIT are held by the requester and arbitrated in the first IDLE cycle.
- A req dropped before its gnt is legal; no access is issued.
- Requester fields are sampled only in the grant cycle.
- Reset during RD_WAIT: the read is abandoned, no rvalid is issued, and the requester must reissue.
- Only one transaction is outstanding at a time; gnt and rvalid never go to both requesters in the same cycle.
- Counter width: 4 bits.

Optional Feature:
ARB_CORE_PRIORITY_EN
- Defined: fixed priority. On a tie the core always wins, rr_last is unused, and the external port may starve while the core requests continuously.
- Undefined (default): round-robin as above; each requester waits at most one foreign transaction when both request.

Test Plan:
- Reset, then core_req=1, we=0, addr=0x100 at cycle 1 → core_gnt=1, mem_en=1, mem_addr=0x100 at cycle 1. Memory returns 0xDEADBEEF at cycle 3 → core_rvalid=1, core_rdata=0xDEADBEEF at cycle 3 (MEM_LAT=2). busy=1 in cycles 2-3.
- core and ext both request reads continuously → grants alternate core, ext, core, …; grants are 3 cycles apart. With ARB_CORE_PRIORITY_EN defined, only core_gnt ever pulses.
- ext write addr=0x20, wdata=0x55 for 3 consecutive cycles (ext_req held, address incremented by 4 after each gnt) → ext_gnt on 3 consecutive cycles; mem_we=1 with addrs 0x20/0x24/0x28; no rvalid.
- ext_req rises during core RD_WAIT → no ext_gnt until the first cycle after core_rvalid; ext_gnt then occurs in the next IDLE cycle.
- Reset asserted one cycle after a core read grant → core_rvalid never pulses, state is IDLE, and the next tie goes to the core.
- MEM_LAT=1 build: read gnt at T → rvalid at T+1; next grant at T+2.
